// File: rtl/l_alu_mem_seq_if.sv
// Memory port bundle for l_alu_mem_seq.
//
// Handshake: the master raises memReq together with memWe, memoryAddress
// and memoryOut, and holds all four steady until it samples memAck high.
// The slave answers with a single-cycle memAck; on a read, memoryIn is
// valid in that same cycle. memReq drops the cycle after memAck.
//
// Signals:
//   memReq        master -> slave  request pending
//   memWe         master -> slave  1 = write, 0 = read
//   memoryAddress master -> slave  request address
//   memoryOut     master -> slave  write data
//   memoryIn      slave -> master  read data (valid with memAck)
//   memAck        slave -> master  one-cycle acknowledge
interface l_alu_mem_seq_if #(
    parameter int WIDTH = 16
);
    logic             memReq;
    logic             memWe;
    logic [WIDTH-1:0] memoryAddress;
    logic [WIDTH-1:0] memoryOut;
    logic [WIDTH-1:0] memoryIn;
    logic             memAck;

    modport master (
        output memReq,
        output memWe,
        output memoryAddress,
        output memoryOut,
        input  memoryIn,
        input  memAck
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memoryAddress,
        input  memoryOut,
        output memoryIn,
        output memAck
    );
endinterface

// File: rtl/l_alu_mem_seq.sv
// Multi-cycle memory/stack execution slot: LOAD, STORE, PUSH, POP, CALL, RET.
// Operands are sampled on start, the effective address is formed and stack
// bounds are checked in CHECK, the memory request runs in REQ with an
// acknowledge timeout, and all results are registered and presented with a
// one-cycle done pulse. busy covers CHECK and REQ.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               launch pulse, only honoured in IDLE
//   control             op code (0 LOAD .. 5 RET, 6-7 illegal)
//   immediate           signed offset for LOAD/STORE
//   in0, in1            base/push data/call target, store data
//   spIn, pcIn, raIn    architectural SP/PC/RA sampled at start
//   out                 load/pop result
//   spOut, pcOut, raOut updated SP/PC/RA
//   busy, done          operation in flight, completion pulse
//   fault               0 none, 1 overflow, 2 underflow, 3 timeout/illegal
//   state_o             current FSM state (debug)
//   mem                 memory request port (master side)
module l_alu_mem_seq #(
    parameter int WIDTH       = 16,
    parameter int IMM_W       = 8,
    parameter int STACK_BASE  = 'hFFFF,
    parameter int STACK_LIMIT = 'hFF00,
    parameter int TIMEOUT     = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       control,
    input  logic [IMM_W-1:0] immediate,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] spIn,
    input  logic [WIDTH-1:0] pcIn,
    input  logic [WIDTH-1:0] raIn,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] spOut,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] raOut,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fault,
    output logic [1:0]       state_o,
    l_alu_mem_seq_if.master  mem
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_REQ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;

    localparam logic [WIDTH-1:0] SP_BASE  = WIDTH'(STACK_BASE);
    localparam logic [WIDTH-1:0] SP_LIMIT = WIDTH'(STACK_LIMIT);
    localparam logic [7:0]       TO_LIM   = 8'(TIMEOUT);

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q, sp_q, pc_q, ra_q;
    logic [7:0]       cnt_q;
    logic             req_q, we_q;
    logic [WIDTH-1:0] addr_q, wdata_q;
    logic [WIDTH-1:0] out_q, sp_out_q, pc_out_q, ra_out_q;
    logic [1:0]       fault_q;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] sp_dec, sp_inc, pc_inc, imm_sext;
    logic [WIDTH-1:0] chk_ea, chk_wdata;
    logic             chk_we;
    logic [1:0]       chk_fault;
    logic [WIDTH-1:0] res_out, res_sp, res_pc, res_ra;
    logic [7:0]       cnt_inc;

    assign sp_dec   = sp_q - 1'b1;
    assign sp_inc   = sp_q + 1'b1;
    assign pc_inc   = pc_q + 1'b1;
    assign imm_sext = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
    assign cnt_inc  = cnt_q + 8'd1;

    // Address, write data and bound check for the sampled op (used in CHECK).
    always_comb begin
        chk_ea    = a_q + imm_q;
        chk_wdata = b_q;
        chk_we    = 1'b0;
        chk_fault = 2'd0;
        case (op_q)
            OP_LOAD: ;
            OP_STORE: chk_we = 1'b1;
            OP_PUSH, OP_CALL: begin
                chk_ea    = sp_dec;
                chk_wdata = (op_q == OP_CALL) ? pc_inc : a_q;
                chk_we    = 1'b1;
                if (sp_q == SP_LIMIT) chk_fault = 2'd1;
            end
            OP_POP, OP_RET: begin
                chk_ea = sp_q;
                if (sp_q == SP_BASE) chk_fault = 2'd2;
            end
            default: chk_fault = 2'd3;
        endcase
    end

    // Architectural results of a successful access (used on memAck).
    always_comb begin
        res_out = '0;
        res_sp  = sp_q;
        res_pc  = pc_inc;
        res_ra  = ra_q;
        case (op_q)
            OP_LOAD: res_out = mem.memoryIn;
            OP_PUSH: res_sp = sp_dec;
            OP_POP: begin
                res_out = mem.memoryIn;
                res_sp  = sp_inc;
            end
            OP_CALL: begin
                res_sp = sp_dec;
                res_ra = pc_inc;
                res_pc = a_q;
            end
            OP_RET: begin
                res_pc = mem.memoryIn;
                res_sp = sp_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sp_q     <= '0;
            pc_q     <= '0;
            ra_q     <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            out_q    <= '0;
            sp_out_q <= '0;
            pc_out_q <= '0;
            ra_out_q <= '0;
            fault_q  <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= control;
                        imm_q   <= imm_sext;
                        a_q     <= in0;
                        b_q     <= in1;
                        sp_q    <= spIn;
                        pc_q    <= pcIn;
                        ra_q    <= raIn;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt_q <= '0;
                    if (chk_fault != 2'd0) begin
                        out_q    <= '0;
                        sp_out_q <= sp_q;
                        pc_out_q <= pc_q;
                        ra_out_q <= ra_q;
                        fault_q  <= chk_fault;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= chk_we;
                        addr_q  <= chk_ea;
                        wdata_q <= chk_wdata;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.memAck) begin
                        // An acknowledge on the last allowed cycle still counts.
                        req_q    <= 1'b0;
                        out_q    <= res_out;
                        sp_out_q <= res_sp;
                        pc_out_q <= res_pc;
                        ra_out_q <= res_ra;
                        fault_q  <= 2'd0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (cnt_inc == TO_LIM) begin
                        // memReq has now been high for TIMEOUT cycles.
                        req_q    <= 1'b0;
                        out_q    <= '0;
                        sp_out_q <= sp_q;
                        pc_out_q <= pc_q;
                        ra_out_q <= ra_q;
                        fault_q  <= 2'd3;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out               = out_q;
    assign spOut             = sp_out_q;
    assign pcOut             = pc_out_q;
    assign raOut             = ra_out_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign fault             = fault_q;
    assign state_o           = state_q;
    assign mem.memReq        = req_q;
    assign mem.memWe         = we_q;
    assign mem.memoryAddress = addr_q;
    assign mem.memoryOut     = wdata_q;
endmodule

// File: tb/tb_l_alu_mem_seq.sv
module tb_l_alu_mem_seq;
    localparam int W     = 16;
    localparam int EXP_W = 2 + 4 * W;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   control;
    logic [7:0]   immediate;
    logic [W-1:0] in0, in1, spIn, pcIn, raIn;
    logic [W-1:0] out, spOut, pcOut, raOut;
    logic         busy, done;
    logic [1:0]   fault;
    logic [1:0]   state_o;

    l_alu_mem_seq_if #(.WIDTH(W)) mif ();

    l_alu_mem_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .control   (control),
        .immediate (immediate),
        .in0       (in0),
        .in1       (in1),
        .spIn      (spIn),
        .pcIn      (pcIn),
        .raIn      (raIn),
        .out       (out),
        .spOut     (spOut),
        .pcOut     (pcOut),
        .raOut     (raOut),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .state_o   (state_o),
        .mem       (mif.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input logic [1:0] f, input logic [W-1:0] o,
                                              input logic [W-1:0] sp, input logic [W-1:0] pc,
                                              input logic [W-1:0] ra);
        return {f, o, sp, pc, ra};
    endfunction

    // ---------------- memory responder ----------------
    logic [W-1:0] mem_model [logic [W-1:0]];
    int           ack_wait = 0;   // wait cycles before ack, -1 = never ack
    int           wait_cnt = 0;
    int           req_cycles = 0;
    int           req_count = 0;
    logic         req_prev = 1'b0;
    logic [W-1:0] last_addr = '0;
    logic         last_we = 1'b0;

    initial begin
        mif.memAck   = 1'b0;
        mif.memoryIn = '0;
        forever begin
            @(negedge clk);
            if (mif.memReq) req_cycles++;
            if (mif.memReq && !req_prev) req_count++;
            req_prev = mif.memReq;
            if (mif.memAck) begin
                mif.memAck = 1'b0;
                wait_cnt   = 0;
            end else if (mif.memReq) begin
                if (ack_wait >= 0 && wait_cnt == ack_wait) begin
                    mif.memAck = 1'b1;
                    last_addr  = mif.memoryAddress;
                    last_we    = mif.memWe;
                    if (mif.memWe) mem_model[mif.memoryAddress] = mif.memoryOut;
                    else mif.memoryIn = mem_model.exists(mif.memoryAddress) ?
                                        mem_model[mif.memoryAddress] : '0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    check("fault", {14'd0, fault}, {14'd0, e[EXP_W-1 -: 2]});
                    check("out",   out,   e[4*W-1 -: W]);
                    check("spOut", spOut, e[3*W-1 -: W]);
                    check("pcOut", pcOut, e[2*W-1 -: W]);
                    check("raOut", raOut, e[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [2:0] op, input logic [7:0] imm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] sp, input logic [W-1:0] pc,
                          input logic [W-1:0] ra, input int wait_cycles, input int exp_lat,
                          input logic [EXP_W-1:0] exp, input bit dup_start);
        int n;
        @(negedge clk);
        ack_wait  = wait_cycles;
        control   = op;
        immediate = imm;
        in0 = a; in1 = b; spIn = sp; pcIn = pc; raIn = ra;
        exp_q.push_back(exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("busy_after_start", {15'd0, busy}, 16'd1);
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (dup_start && n == 2) begin
                start = 1'b1; control = 3'd3; spIn = 16'hFFFF; in0 = 16'h7777;
            end else if (dup_start && n == 3) begin
                start = 1'b0;
            end
        end
        check("latency", 16'(n), 16'(exp_lat));
        check("busy_at_done", {15'd0, busy}, 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rc;
        start = 0; control = 0; immediate = 0;
        in0 = 0; in1 = 0; spIn = 0; pcIn = 0; raIn = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_out", out, 16'h0);
        check("reset_spOut", spOut, 16'h0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_memReq", {15'd0, mif.memReq}, 16'd0);
        check("reset_state", {14'd0, state_o}, 16'd0);

        mem_model[16'h00FE] = 16'hBEEF;

        // LOAD with two wait cycles; imm 0xFE sign-extends to -2
        run_op(3'd0, 8'hFE, 16'h0100, 16'h0, 16'hFFFF, 16'h0020, 16'h0005, 2, 5,
               pack(2'd0, 16'hBEEF, 16'hFFFF, 16'h0021, 16'h0005), 1'b0);
        check("load_addr", last_addr, 16'h00FE);
        check("load_we", {15'd0, last_we}, 16'd0);

        // PUSH then POP
        run_op(3'd2, 8'h00, 16'h1234, 16'h0, 16'hFFFF, 16'h0030, 16'h0000, 0, 3,
               pack(2'd0, 16'h0000, 16'hFFFE, 16'h0031, 16'h0000), 1'b0);
        check("push_addr", last_addr, 16'hFFFE);
        check("push_we", {15'd0, last_we}, 16'd1);
        check("push_mem", mem_model[16'hFFFE], 16'h1234);
        run_op(3'd3, 8'h00, 16'h0, 16'h0, 16'hFFFE, 16'h0031, 16'h0000, 0, 3,
               pack(2'd0, 16'h1234, 16'hFFFF, 16'h0032, 16'h0000), 1'b0);

        // CALL then RET
        run_op(3'd4, 8'h00, 16'h0040, 16'h0, 16'hFFFF, 16'h0010, 16'h0099, 0, 3,
               pack(2'd0, 16'h0000, 16'hFFFE, 16'h0040, 16'h0011), 1'b0);
        check("call_mem", mem_model[16'hFFFE], 16'h0011);
        run_op(3'd5, 8'h00, 16'h0, 16'h0, 16'hFFFE, 16'h0040, 16'h0011, 0, 3,
               pack(2'd0, 16'h0000, 16'hFFFF, 16'h0011, 16'h0011), 1'b0);

        // stack bounds: overflow, underflow, last legal push
        rc = req_count;
        run_op(3'd2, 8'h00, 16'hAAAA, 16'h0, 16'hFF00, 16'h0050, 16'h0007, 0, 2,
               pack(2'd1, 16'h0000, 16'hFF00, 16'h0050, 16'h0007), 1'b0);
        run_op(3'd3, 8'h00, 16'h0, 16'h0, 16'hFFFF, 16'h0051, 16'h0007, 0, 2,
               pack(2'd2, 16'h0000, 16'hFFFF, 16'h0051, 16'h0007), 1'b0);
        check("fault_no_req", 16'(req_count), 16'(rc));
        run_op(3'd2, 8'h00, 16'h4321, 16'h0, 16'hFF01, 16'h0052, 16'h0007, 1, 4,
               pack(2'd0, 16'h0000, 16'hFF00, 16'h0053, 16'h0007), 1'b0);
        check("push_limit_mem", mem_model[16'hFF00], 16'h4321);

        // illegal op
        run_op(3'd6, 8'h00, 16'h0, 16'h0, 16'h1000, 16'h0060, 16'h0008, 0, 2,
               pack(2'd3, 16'h0000, 16'h1000, 16'h0060, 16'h0008), 1'b0);

        // STORE timeout, then ack on the 15th request cycle
        req_cycles = 0;
        run_op(3'd1, 8'h10, 16'h2000, 16'h5555, 16'hFFFF, 16'h0060, 16'h0001, -1, 17,
               pack(2'd3, 16'h0000, 16'hFFFF, 16'h0060, 16'h0001), 1'b0);
        check("timeout_req_cycles", 16'(req_cycles), 16'd15);
        run_op(3'd1, 8'h10, 16'h2000, 16'h5555, 16'hFFFF, 16'h0061, 16'h0001, 14, 17,
               pack(2'd0, 16'h0000, 16'hFFFF, 16'h0062, 16'h0001), 1'b0);
        check("late_ack_mem", mem_model[16'h2010], 16'h5555);

        // negative offset store, then read back
        run_op(3'd1, 8'h80, 16'h0100, 16'h1111, 16'hFFFF, 16'h0070, 16'h0002, 1, 4,
               pack(2'd0, 16'h0000, 16'hFFFF, 16'h0071, 16'h0002), 1'b0);
        check("neg_imm_addr", last_addr, 16'h0080);
        run_op(3'd0, 8'h00, 16'h0080, 16'h0, 16'hFFFF, 16'h0071, 16'h0002, 0, 3,
               pack(2'd0, 16'h1111, 16'hFFFF, 16'h0072, 16'h0002), 1'b0);

        // start while busy is ignored
        rc = req_count;
        run_op(3'd0, 8'hFE, 16'h0100, 16'h0, 16'hFFFF, 16'h0080, 16'h0003, 2, 5,
               pack(2'd0, 16'hBEEF, 16'hFFFF, 16'h0081, 16'h0003), 1'b1);
        repeat (6) @(negedge clk);
        check("busy_start_one_req", 16'(req_count), 16'(rc + 1));
        check("busy_start_idle", {15'd0, busy}, 16'd0);

        // reset during REQ aborts without done
        @(negedge clk);
        ack_wait = -1;
        control = 3'd1; immediate = 8'h00; in0 = 16'h3000; in1 = 16'h9999;
        spIn = 16'hFFFF; pcIn = 16'h0090; raIn = 16'h0004;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_memReq", {15'd0, mif.memReq}, 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_memReq", {15'd0, mif.memReq}, 16'd0);
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_out", out, 16'h0);
        repeat (20) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
